// File: rtl/adder.sv
// Registered (N+1)-bit unsigned adder built from an N-stage ripple-carry chain of full-adder cells.
// Latency: 1 cycle from sampled a/b/carry_in to c/carry_out; throughput one result per cycle.
// Backpressure: none; a new result is captured on every rising edge while rst_n is high.
module adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] c,
    output logic         carry_out
);

    // carry[i] is the carry into stage i; carry[N] is the carry out of the top stage.
    logic [N:0]   carry;
    logic [N-1:0] sum;

    assign carry[0] = carry_in;

    // One full-adder cell per bit, chained through carry. Written as plain
    // gate equations so X/Z on any input propagates instead of being masked.
    for (genvar i = 0; i < N; i++) begin : g_stage
        logic x;
        logic y;
        logic ci;
        logic p;

        assign x          = a[i];
        assign y          = b[i];
        assign ci         = carry[i];
        assign p          = x ^ y;
        assign sum[i]     = p ^ ci;
        assign carry[i+1] = (x & y) | (ci & p);
    end

    // Output register: synchronous reset wins over capture, otherwise take this edge's sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c         <= '0;
            carry_out <= 1'b0;
        end else begin
            c         <= sum;
            carry_out <= carry[N];
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed and random checks of the registered ripple-carry adder at N=8 and N=1.
// Inputs change #1 after a rising edge; results are read #1 after the next rising edge.
// Expected values are hand-computed constants or an integer reference sum.
module tb_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic [7:0] c8;
    logic       co8;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic [0:0] c1;
    logic       co1;

    int tests;
    int fails;

    adder #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .c         (c8),
        .carry_out (co8)
    );

    adder #(.N(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .carry_in  (cin1),
        .c         (c1),
        .carry_out (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and come back #1 later to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        a8   = av;
        b8   = bv;
        cin8 = ci;
    endtask

    initial begin
        int unsigned ra;
        int unsigned rb;
        int unsigned rc;
        logic [8:0]  exp8;
        logic [8:0]  exp1;
        logic [8:0]  prev8;
        logic [8:0]  prev1;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive8(8'hAA, 8'h77, 1'b1);
        a1    = 1'b1;
        b1    = 1'b1;
        cin1  = 1'b1;

        // Reset with non-zero inputs present.
        tick();
        check("reset_n8", {co8, c8}, 9'h000);
        check("reset_n1", {7'd0, co1, c1}, 9'h000);
        tick();
        check("reset_hold_n8", {co8, c8}, 9'h000);

        // First edge after release captures inputs normally.
        rst_n = 1'b1;
        drive8(8'h00, 8'h00, 1'b0);
        tick();
        check("zero", {co8, c8}, 9'h000);
        check("n1_first_after_reset", {7'd0, co1, c1}, 9'h003);

        drive8(8'hBD, 8'hA5, 1'b0);
        tick();
        check("bd_a5", {co8, c8}, 9'h162);

        drive8(8'hF0, 8'h0F, 1'b0);
        tick();
        check("f0_0f", {co8, c8}, 9'h0FF);

        drive8(8'hF0, 8'h8F, 1'b0);
        tick();
        check("f0_8f", {co8, c8}, 9'h17F);

        drive8(8'hFF, 8'h00, 1'b1);
        tick();
        check("ff_00_cin", {co8, c8}, 9'h100);

        drive8(8'hFF, 8'hFF, 1'b1);
        tick();
        check("max", {co8, c8}, 9'h1FF);

        drive8(8'h55, 8'hAA, 1'b0);
        tick();
        check("alt_bits", {co8, c8}, 9'h0FF);

        drive8(8'h01, 8'h7F, 1'b1);
        tick();
        check("cin_ripple", {co8, c8}, 9'h081);

        // Back-to-back stream; result one cycle after each input set.
        drive8(8'h12, 8'h34, 1'b0);
        tick();
        check("stream0", {co8, c8}, 9'h046);
        drive8(8'h80, 8'h80, 1'b0);
        tick();
        check("stream1", {co8, c8}, 9'h100);

        // Reset pulse mid-stream discards the in-flight result.
        drive8(8'h3C, 8'h4D, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_reset", {co8, c8}, 9'h000);
        rst_n = 1'b1;
        tick();
        check("after_mid_reset", {co8, c8}, 9'h08A);

        // N=1 exhaustive small vectors.
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
        tick();
        check("n1_001", {7'd0, co1, c1}, 9'h001);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        tick();
        check("n1_110", {7'd0, co1, c1}, 9'h002);

        // Random stream on both widths against an integer reference, one cycle delayed.
        ra = $urandom_range(255); rb = $urandom_range(255); rc = $urandom_range(1);
        drive8(ra[7:0], rb[7:0], rc[0]);
        prev8 = 9'(ra + rb + rc);
        ra = $urandom_range(1); rb = $urandom_range(1); rc = $urandom_range(1);
        a1 = ra[0]; b1 = rb[0]; cin1 = rc[0];
        prev1 = 9'(ra + rb + rc);
        for (int i = 0; i < 1000; i++) begin
            tick();
            exp8 = prev8;
            exp1 = prev1;
            check("rand_n8", {co8, c8}, exp8);
            check("rand_n1", {7'd0, co1, c1}, exp1);
            ra = $urandom_range(255); rb = $urandom_range(255); rc = $urandom_range(1);
            drive8(ra[7:0], rb[7:0], rc[0]);
            prev8 = 9'(ra + rb + rc);
            ra = $urandom_range(1); rb = $urandom_range(1); rc = $urandom_range(1);
            a1 = ra[0]; b1 = rb[0]; cin1 = rc[0];
            prev1 = 9'(ra + rb + rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
